axil_region_router: RTL and testbench

- Parametrised successor to the single-region-map memory controller.
- Accepts AXI4-Lite read and write transactions from the CPU and decodes address bits [SEL_MSB:SEL_LSB] to one of NUM_SLAVES downstream slave ports, each using a simple req/ack bus.
- Adds byte strobes, BRESP/RRESP error reporting, AW/W accepted in either order, and an optional per-transaction timeout.
- Read and write paths are fully independent and may run concurrently.

---
 rtl/axil_region_router_if.sv | 57 +++++
 rtl/axil_region_router.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_axil_region_router.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_region_router_if.sv
// Bus bundle for axil_region_router: AXI4-Lite CPU side plus the req/ack slave side.
// Modports:
//   slave  - router view: accepts AXI requests, drives responses and slave requests.
//   master - environment view: drives AXI requests and slave acks/read data.
interface axil_region_router_if #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic                         mem_axi_awvalid;
    logic                         mem_axi_awready;
    logic [ADDR_W-1:0]            mem_axi_awaddr;
    logic                         mem_axi_wvalid;
    logic                         mem_axi_wready;
    logic [DATA_W-1:0]            mem_axi_wdata;
    logic [STRB_W-1:0]            mem_axi_wstrb;
    logic                         mem_axi_bvalid;
    logic                         mem_axi_bready;
    logic [1:0]                   mem_axi_bresp;
    logic                         mem_axi_arvalid;
    logic                         mem_axi_arready;
    logic [ADDR_W-1:0]            mem_axi_araddr;
    logic                         mem_axi_rvalid;
    logic                         mem_axi_rready;
    logic [DATA_W-1:0]            mem_axi_rdata;
    logic [1:0]                   mem_axi_rresp;

    logic [ADDR_W-1:0]            slv_rd_addr;
    logic [NUM_SLAVES-1:0]        slv_rd_req;
    logic [NUM_SLAVES-1:0]        slv_rd_ack;
    logic [NUM_SLAVES*DATA_W-1:0] slv_rd_data;
    logic [ADDR_W-1:0]            slv_wr_addr;
    logic [DATA_W-1:0]            slv_wr_data;
    logic [STRB_W-1:0]            slv_wr_strb;
    logic [NUM_SLAVES-1:0]        slv_wr_req;
    logic [NUM_SLAVES-1:0]        slv_wr_ack;

    modport slave (
        input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
               mem_axi_bready, mem_axi_arvalid, mem_axi_araddr, mem_axi_rready,
               slv_rd_ack, slv_rd_data, slv_wr_ack,
        output mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_bresp,
               mem_axi_arready, mem_axi_rvalid, mem_axi_rdata, mem_axi_rresp,
               slv_rd_addr, slv_rd_req, slv_wr_addr, slv_wr_data, slv_wr_strb, slv_wr_req
    );

    modport master (
        output mem_axi_awvalid, mem_axi_awaddr, mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
               mem_axi_bready, mem_axi_arvalid, mem_axi_araddr, mem_axi_rready,
               slv_rd_ack, slv_rd_data, slv_wr_ack,
        input  mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_bresp,
               mem_axi_arready, mem_axi_rvalid, mem_axi_rdata, mem_axi_rresp,
               slv_rd_addr, slv_rd_req, slv_wr_addr, slv_wr_data, slv_wr_strb, slv_wr_req
    );
endinterface

// File: rtl/axil_region_router.sv
// AXI4-Lite to multi-slave req/ack router. Address bits [SEL_MSB:SEL_LSB] pick one of
// NUM_SLAVES ports; unmapped selects answer DECERR without touching any slave.
// Read and write paths are independent FSMs; AW and W may arrive in any order.
// Ports:
//   CLK   - clock
//   RSTb  - synchronous active-low reset
//   bus   - axil_region_router_if.slave (AXI4-Lite channels and slave req/ack buses)
// Optional: define AXIL_REGION_ROUTER_TIMEOUT_EN to answer SLVERR when a slave
// does not ack within TIMEOUT_CYCLES request cycles.
module axil_region_router #(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned SEL_MSB        = 31,
    parameter int unsigned SEL_LSB        = 28,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                  CLK,
    input logic                  RSTb,
    axil_region_router_if.slave  bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SEL_W  = SEL_MSB - SEL_LSB + 1;
    // Compare width holds both the full select field and NUM_SLAVES (<= 16).
    localparam int unsigned CMP_W  = (SEL_W > 5) ? SEL_W : 5;
    localparam int unsigned IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] R_IDLE = 2'd0, R_REQ = 2'd1, R_RESP = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2;

`ifdef AXIL_REGION_ROUTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    // Full-width unsigned compare; high select bits are never dropped.
    function automatic logic is_mapped(input logic [SEL_W-1:0] sel);
        return CMP_W'(sel) < CMP_W'(NUM_SLAVES);
    endfunction

    // ---------------- read path state ----------------
    logic [1:0]            r_state, r_state_nxt;
    logic                  arready, arready_nxt;
    logic                  rvalid, rvalid_nxt;
    logic [DATA_W-1:0]     rdata, rdata_nxt;
    logic [1:0]            rresp, rresp_nxt;
    logic [ADDR_W-1:0]     rd_addr, rd_addr_nxt;
    logic [NUM_SLAVES-1:0] rd_req, rd_req_nxt;
    logic [IDX_W-1:0]      r_sel, r_sel_nxt;
    logic [SEL_W-1:0]      r_sel_raw;
`ifdef AXIL_REGION_ROUTER_TIMEOUT_EN
    logic [CNT_W-1:0]      r_cnt, r_cnt_nxt;
`endif

    // Read next-state and next-output logic.
    always_comb begin
        r_state_nxt = r_state;
        arready_nxt = arready;
        rvalid_nxt  = rvalid;
        rdata_nxt   = rdata;
        rresp_nxt   = rresp;
        rd_addr_nxt = rd_addr;
        rd_req_nxt  = rd_req;
        r_sel_nxt   = r_sel;
        r_sel_raw   = bus.mem_axi_araddr[SEL_MSB:SEL_LSB];
`ifdef AXIL_REGION_ROUTER_TIMEOUT_EN
        r_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            R_IDLE: begin
                arready_nxt = 1'b1;
                if (bus.mem_axi_arvalid && arready) begin
                    arready_nxt = 1'b0;
                    rd_addr_nxt = bus.mem_axi_araddr;
                    if (is_mapped(r_sel_raw)) begin
                        r_sel_nxt   = IDX_W'(r_sel_raw);
                        rd_req_nxt  = NUM_SLAVES'(1) << r_sel_nxt;
                        r_state_nxt = R_REQ;
`ifdef AXIL_REGION_ROUTER_TIMEOUT_EN
                        r_cnt_nxt   = '0;
`endif
                    end else begin
                        rdata_nxt   = '0;
                        rresp_nxt   = RESP_DECERR;
                        rvalid_nxt  = 1'b1;
                        r_state_nxt = R_RESP;
                    end
                end
            end
            R_REQ: begin
                if (bus.slv_rd_ack[r_sel]) begin
                    rdata_nxt   = bus.slv_rd_data[r_sel*DATA_W +: DATA_W];
                    rresp_nxt   = RESP_OKAY;
                    rd_req_nxt  = '0;
                    rvalid_nxt  = 1'b1;
                    r_state_nxt = R_RESP;
                end
`ifdef AXIL_REGION_ROUTER_TIMEOUT_EN
                // Ack on the limit cycle takes priority (branch above).
                else if (r_cnt == CNT_LAST) begin
                    rdata_nxt   = '0;
                    rresp_nxt   = RESP_SLVERR;
                    rd_req_nxt  = '0;
                    rvalid_nxt  = 1'b1;
                    r_state_nxt = R_RESP;
                end else begin
                    r_cnt_nxt   = r_cnt + 1'b1;
                end
`endif
            end
            R_RESP: begin
                if (bus.mem_axi_rready) begin
                    rvalid_nxt  = 1'b0;
                    arready_nxt = 1'b1;
                    r_state_nxt = R_IDLE;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read state and output registers.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= '0;
            rd_addr <= '0;
            rd_req  <= '0;
            r_sel   <= '0;
`ifdef AXIL_REGION_ROUTER_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= r_state_nxt;
            arready <= arready_nxt;
            rvalid  <= rvalid_nxt;
            rdata   <= rdata_nxt;
            rresp   <= rresp_nxt;
            rd_addr <= rd_addr_nxt;
            rd_req  <= rd_req_nxt;
            r_sel   <= r_sel_nxt;
`ifdef AXIL_REGION_ROUTER_TIMEOUT_EN
            r_cnt   <= r_cnt_nxt;
`endif
        end
    end

    // ---------------- write path state ----------------
    logic [1:0]            w_state, w_state_nxt;
    logic                  awready, awready_nxt;
    logic                  wready, wready_nxt;
    logic                  aw_held, aw_held_nxt;
    logic                  w_held, w_held_nxt;
    logic                  bvalid, bvalid_nxt;
    logic [1:0]            bresp, bresp_nxt;
    logic [ADDR_W-1:0]     wr_addr, wr_addr_nxt;
    logic [DATA_W-1:0]     wr_data, wr_data_nxt;
    logic [STRB_W-1:0]     wr_strb, wr_strb_nxt;
    logic [NUM_SLAVES-1:0] wr_req, wr_req_nxt;
    logic [IDX_W-1:0]      w_sel, w_sel_nxt;
    logic [SEL_W-1:0]      w_sel_raw;
`ifdef AXIL_REGION_ROUTER_TIMEOUT_EN
    logic [CNT_W-1:0]      w_cnt, w_cnt_nxt;
`endif

    // Write next-state and next-output logic; decode uses the just-captured address.
    always_comb begin
        w_state_nxt = w_state;
        awready_nxt = awready;
        wready_nxt  = wready;
        aw_held_nxt = aw_held;
        w_held_nxt  = w_held;
        bvalid_nxt  = bvalid;
        bresp_nxt   = bresp;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        wr_strb_nxt = wr_strb;
        wr_req_nxt  = wr_req;
        w_sel_nxt   = w_sel;
        w_sel_raw   = '0;
`ifdef AXIL_REGION_ROUTER_TIMEOUT_EN
        w_cnt_nxt   = w_cnt;
`endif
        case (w_state)
            W_IDLE: begin
                awready_nxt = !aw_held;
                wready_nxt  = !w_held;
                if (bus.mem_axi_awvalid && awready) begin
                    wr_addr_nxt = bus.mem_axi_awaddr;
                    aw_held_nxt = 1'b1;
                    awready_nxt = 1'b0;
                end
                if (bus.mem_axi_wvalid && wready) begin
                    wr_data_nxt = bus.mem_axi_wdata;
                    wr_strb_nxt = bus.mem_axi_wstrb;
                    w_held_nxt  = 1'b1;
                    wready_nxt  = 1'b0;
                end
                if (aw_held_nxt && w_held_nxt) begin
                    w_sel_raw = wr_addr_nxt[SEL_MSB:SEL_LSB];
                    if (is_mapped(w_sel_raw)) begin
                        w_sel_nxt   = IDX_W'(w_sel_raw);
                        wr_req_nxt  = NUM_SLAVES'(1) << w_sel_nxt;
                        w_state_nxt = W_REQ;
`ifdef AXIL_REGION_ROUTER_TIMEOUT_EN
                        w_cnt_nxt   = '0;
`endif
                    end else begin
                        bresp_nxt   = RESP_DECERR;
                        bvalid_nxt  = 1'b1;
                        w_state_nxt = W_RESP;
                    end
                end
            end
            W_REQ: begin
                if (bus.slv_wr_ack[w_sel]) begin
                    bresp_nxt   = RESP_OKAY;
                    wr_req_nxt  = '0;
                    bvalid_nxt  = 1'b1;
                    w_state_nxt = W_RESP;
                end
`ifdef AXIL_REGION_ROUTER_TIMEOUT_EN
                else if (w_cnt == CNT_LAST) begin
                    bresp_nxt   = RESP_SLVERR;
                    wr_req_nxt  = '0;
                    bvalid_nxt  = 1'b1;
                    w_state_nxt = W_RESP;
                end else begin
                    w_cnt_nxt   = w_cnt + 1'b1;
                end
`endif
            end
            W_RESP: begin
                if (bus.mem_axi_bready) begin
                    bvalid_nxt  = 1'b0;
                    aw_held_nxt = 1'b0;
                    w_held_nxt  = 1'b0;
                    awready_nxt = 1'b1;
                    wready_nxt  = 1'b1;
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write state and output registers.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_strb <= '0;
            wr_req  <= '0;
            w_sel   <= '0;
`ifdef AXIL_REGION_ROUTER_TIMEOUT_EN
            w_cnt   <= '0;
`endif
        end else begin
            w_state <= w_state_nxt;
            awready <= awready_nxt;
            wready  <= wready_nxt;
            aw_held <= aw_held_nxt;
            w_held  <= w_held_nxt;
            bvalid  <= bvalid_nxt;
            bresp   <= bresp_nxt;
            wr_addr <= wr_addr_nxt;
            wr_data <= wr_data_nxt;
            wr_strb <= wr_strb_nxt;
            wr_req  <= wr_req_nxt;
            w_sel   <= w_sel_nxt;
`ifdef AXIL_REGION_ROUTER_TIMEOUT_EN
            w_cnt   <= w_cnt_nxt;
`endif
        end
    end

    assign bus.mem_axi_arready = arready;
    assign bus.mem_axi_rvalid  = rvalid;
    assign bus.mem_axi_rdata   = rdata;
    assign bus.mem_axi_rresp   = rresp;
    assign bus.slv_rd_addr     = rd_addr;
    assign bus.slv_rd_req      = rd_req;
    assign bus.mem_axi_awready = awready;
    assign bus.mem_axi_wready  = wready;
    assign bus.mem_axi_bvalid  = bvalid;
    assign bus.mem_axi_bresp   = bresp;
    assign bus.slv_wr_addr     = wr_addr;
    assign bus.slv_wr_data     = wr_data;
    assign bus.slv_wr_strb     = wr_strb;
    assign bus.slv_wr_req      = wr_req;
endmodule

// File: tb/tb_axil_region_router.sv
// Directed bench for axil_region_router (4 slaves, 32-bit, select bits [31:28]).
module tb_axil_region_router;
    localparam int unsigned NS = 4;
    localparam int unsigned DW = 32;

    logic CLK  = 1'b0;
    logic RSTb = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 CLK = ~CLK;

    axil_region_router_if #(.NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(DW)) bus ();

    axil_region_router #(
        .NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(DW),
        .SEL_MSB(31), .SEL_LSB(28), .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK  (CLK),
        .RSTb (RSTb),
        .bus  (bus)
    );

    // Rising-edge counters of each request line.
    int       rd_rise [NS];
    int       wr_rise [NS];
    int       rd_base [NS];
    int       wr_base [NS];
    logic [NS-1:0] rd_prev = '0;
    logic [NS-1:0] wr_prev = '0;

    initial begin
        for (int i = 0; i < int'(NS); i++) begin
            rd_rise[i] = 0;
            wr_rise[i] = 0;
        end
    end

    always @(negedge CLK) begin
        for (int i = 0; i < int'(NS); i++) begin
            if (bus.slv_rd_req[i] === 1'b1 && rd_prev[i] !== 1'b1) rd_rise[i]++;
            if (bus.slv_wr_req[i] === 1'b1 && wr_prev[i] !== 1'b1) wr_rise[i]++;
        end
        rd_prev = bus.slv_rd_req;
        wr_prev = bus.slv_wr_req;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < int'(NS); i++) begin
            rd_base[i] = rd_rise[i];
            wr_base[i] = wr_rise[i];
        end
    endtask

    // Expect exactly one request pulse on rd_slv / wr_slv (-1 = none) since snap().
    task automatic chk_rises(input string tag, input int rd_slv, input int wr_slv);
        for (int i = 0; i < int'(NS); i++) begin
            chk({tag, "_rd"}, 32'(rd_rise[i] - rd_base[i]), (i == rd_slv) ? 32'd1 : 32'd0);
            chk({tag, "_wr"}, 32'(wr_rise[i] - wr_base[i]), (i == wr_slv) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic set_rd_data(input int idx, input logic [31:0] val);
        bus.slv_rd_data[idx*32 +: 32] = val;
    endtask

    initial begin
        bus.mem_axi_awvalid = 1'b0;
        bus.mem_axi_awaddr  = '0;
        bus.mem_axi_wvalid  = 1'b0;
        bus.mem_axi_wdata   = '0;
        bus.mem_axi_wstrb   = '0;
        bus.mem_axi_bready  = 1'b0;
        bus.mem_axi_arvalid = 1'b0;
        bus.mem_axi_araddr  = '0;
        bus.mem_axi_rready  = 1'b0;
        bus.slv_rd_ack      = '0;
        bus.slv_rd_data     = '0;
        bus.slv_wr_ack      = '0;

        // Reset state
        tick();
        tick();
        chk("rst_arready", 32'(bus.mem_axi_arready), 32'd0);
        chk("rst_awready", 32'(bus.mem_axi_awready), 32'd0);
        chk("rst_wready",  32'(bus.mem_axi_wready),  32'd0);
        chk("rst_rvalid",  32'(bus.mem_axi_rvalid),  32'd0);
        chk("rst_bvalid",  32'(bus.mem_axi_bvalid),  32'd0);
        chk("rst_rd_req",  32'(bus.slv_rd_req),      32'd0);
        chk("rst_wr_req",  32'(bus.slv_wr_req),      32'd0);
        chk("rst_rdata",   bus.mem_axi_rdata,        32'd0);
        RSTb = 1'b1;
        tick();
        chk("idle_arready", 32'(bus.mem_axi_arready), 32'd1);
        chk("idle_awready", 32'(bus.mem_axi_awready), 32'd1);
        chk("idle_wready",  32'(bus.mem_axi_wready),  32'd1);

        // Read to slave 1, ack two cycles after req
        snap();
        set_rd_data(0, 32'hDEAD_BEEF);
        set_rd_data(1, 32'hCAFE_F00D);
        set_rd_data(2, 32'h1234_5678);
        bus.mem_axi_araddr  = 32'h1000_0004;
        bus.mem_axi_arvalid = 1'b1;
        tick();
        bus.mem_axi_arvalid = 1'b0;
        chk("rd1_arready", 32'(bus.mem_axi_arready), 32'd0);
        chk("rd1_req",     32'(bus.slv_rd_req),      32'b0010);
        chk("rd1_addr",    bus.slv_rd_addr,          32'h1000_0004);
        tick();
        chk("rd1_req_hold", 32'(bus.slv_rd_req), 32'b0010);
        chk("rd1_novalid",  32'(bus.mem_axi_rvalid), 32'd0);
        tick();
        bus.slv_rd_ack = 4'b0010;
        tick();
        bus.slv_rd_ack = '0;
        chk("rd1_rvalid", 32'(bus.mem_axi_rvalid), 32'd1);
        chk("rd1_rdata",  bus.mem_axi_rdata,       32'hCAFE_F00D);
        chk("rd1_rresp",  32'(bus.mem_axi_rresp),  32'd0);
        chk("rd1_req_off", 32'(bus.slv_rd_req),    32'd0);
        bus.mem_axi_rready = 1'b1;
        tick();
        bus.mem_axi_rready = 1'b0;
        chk("rd1_rvalid_off", 32'(bus.mem_axi_rvalid),  32'd0);
        chk("rd1_arready_back", 32'(bus.mem_axi_arready), 32'd1);
        chk_rises("rd1_rise", 1, -1);

        // Write: W three cycles before AW, slave 2 acks immediately
        snap();
        bus.mem_axi_wdata  = 32'h1122_3344;
        bus.mem_axi_wstrb  = 4'b0101;
        bus.mem_axi_wvalid = 1'b1;
        tick();
        bus.mem_axi_wvalid = 1'b0;
        chk("wr2_wready_low",  32'(bus.mem_axi_wready),  32'd0);
        chk("wr2_awready_hi",  32'(bus.mem_axi_awready), 32'd1);
        tick();
        tick();
        chk("wr2_idle_noreq", 32'(bus.slv_wr_req), 32'd0);
        bus.mem_axi_awaddr  = 32'h2000_0008;
        bus.mem_axi_awvalid = 1'b1;
        tick();
        bus.mem_axi_awvalid = 1'b0;
        chk("wr2_req",     32'(bus.slv_wr_req),      32'b0100);
        chk("wr2_addr",    bus.slv_wr_addr,          32'h2000_0008);
        chk("wr2_data",    bus.slv_wr_data,          32'h1122_3344);
        chk("wr2_strb",    32'(bus.slv_wr_strb),     32'b0101);
        chk("wr2_awready", 32'(bus.mem_axi_awready), 32'd0);
        bus.slv_wr_ack = 4'b0100;
        tick();
        bus.slv_wr_ack = '0;
        chk("wr2_bvalid",  32'(bus.mem_axi_bvalid), 32'd1);
        chk("wr2_bresp",   32'(bus.mem_axi_bresp),  32'd0);
        chk("wr2_req_off", 32'(bus.slv_wr_req),     32'd0);
        bus.mem_axi_bready = 1'b1;
        tick();
        bus.mem_axi_bready = 1'b0;
        chk("wr2_bvalid_off", 32'(bus.mem_axi_bvalid),  32'd0);
        chk("wr2_awready_back", 32'(bus.mem_axi_awready), 32'd1);
        chk("wr2_wready_back",  32'(bus.mem_axi_wready),  32'd1);
        chk_rises("wr2_rise", -1, 2);

        // Unmapped read and write in the same cycle
        snap();
        set_rd_data(3, 32'hFFFF_FFFF);
        bus.mem_axi_araddr  = 32'h7000_0000;
        bus.mem_axi_arvalid = 1'b1;
        bus.mem_axi_awaddr  = 32'hF000_0000;
        bus.mem_axi_awvalid = 1'b1;
        bus.mem_axi_wdata   = 32'hAAAA_5555;
        bus.mem_axi_wstrb   = 4'b1111;
        bus.mem_axi_wvalid  = 1'b1;
        tick();
        bus.mem_axi_arvalid = 1'b0;
        bus.mem_axi_awvalid = 1'b0;
        bus.mem_axi_wvalid  = 1'b0;
        chk("dec_rvalid", 32'(bus.mem_axi_rvalid), 32'd1);
        chk("dec_rresp",  32'(bus.mem_axi_rresp),  32'b11);
        chk("dec_rdata",  bus.mem_axi_rdata,       32'd0);
        chk("dec_bvalid", 32'(bus.mem_axi_bvalid), 32'd1);
        chk("dec_bresp",  32'(bus.mem_axi_bresp),  32'b11);
        bus.mem_axi_rready = 1'b1;
        bus.mem_axi_bready = 1'b1;
        tick();
        bus.mem_axi_rready = 1'b0;
        bus.mem_axi_bready = 1'b0;
        chk("dec_rvalid_off", 32'(bus.mem_axi_rvalid), 32'd0);
        chk("dec_bvalid_off", 32'(bus.mem_axi_bvalid), 32'd0);
        chk_rises("dec_rise", -1, -1);

        // Read backpressure on slave 3: response held while rready low
        snap();
        set_rd_data(3, 32'hA5A5_5A5A);
        bus.mem_axi_araddr  = 32'h3000_0010;
        bus.mem_axi_arvalid = 1'b1;
        tick();
        bus.mem_axi_arvalid = 1'b0;
        chk("bp_req", 32'(bus.slv_rd_req), 32'b1000);
        bus.slv_rd_ack = 4'b1000;
        tick();
        bus.slv_rd_ack = '0;
        set_rd_data(3, 32'h0000_0000);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvalid",  32'(bus.mem_axi_rvalid),  32'd1);
            chk("bp_rdata",   bus.mem_axi_rdata,        32'hA5A5_5A5A);
            chk("bp_arready", 32'(bus.mem_axi_arready), 32'd0);
            tick();
        end
        chk("bp_rvalid_end", 32'(bus.mem_axi_rvalid), 32'd1);
        bus.mem_axi_rready = 1'b1;
        tick();
        bus.mem_axi_rready = 1'b0;
        chk("bp_rvalid_off", 32'(bus.mem_axi_rvalid),  32'd0);
        chk("bp_arready_on", 32'(bus.mem_axi_arready), 32'd1);
        chk_rises("bp_rise", 3, -1);

`ifdef AXIL_REGION_ROUTER_TIMEOUT_EN
        // Slave 0 never acks: timeout after 8 request cycles
        snap();
        set_rd_data(0, 32'h7777_7777);
        bus.mem_axi_araddr  = 32'h0000_0000;
        bus.mem_axi_arvalid = 1'b1;
        tick();
        bus.mem_axi_arvalid = 1'b0;
        chk("to_req_first", 32'(bus.slv_rd_req), 32'b0001);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_req_hold", 32'(bus.slv_rd_req), 32'b0001);
        end
        tick();
        chk("to_req_off", 32'(bus.slv_rd_req),     32'd0);
        chk("to_rvalid",  32'(bus.mem_axi_rvalid), 32'd1);
        chk("to_rresp",   32'(bus.mem_axi_rresp),  32'b10);
        chk("to_rdata",   bus.mem_axi_rdata,       32'd0);
        bus.slv_rd_ack     = 4'b0001;
        bus.mem_axi_rready = 1'b1;
        tick();
        bus.mem_axi_rready = 1'b0;
        chk("to_rvalid_off", 32'(bus.mem_axi_rvalid), 32'd0);
        tick();
        bus.slv_rd_ack = '0;
        chk("to_no_second", 32'(bus.mem_axi_rvalid),  32'd0);
        chk("to_idle",      32'(bus.mem_axi_arready), 32'd1);
        chk_rises("to_rise", 0, -1);
`endif

        // Reset while in W_REQ, then a clean write to slave 1
        bus.mem_axi_awaddr  = 32'h1000_0020;
        bus.mem_axi_wdata   = 32'h0000_55AA;
        bus.mem_axi_wstrb   = 4'b1111;
        bus.mem_axi_awvalid = 1'b1;
        bus.mem_axi_wvalid  = 1'b1;
        tick();
        bus.mem_axi_awvalid = 1'b0;
        bus.mem_axi_wvalid  = 1'b0;
        chk("rw_req_pre", 32'(bus.slv_wr_req), 32'b0010);
        RSTb = 1'b0;
        tick();
        chk("rw_req_rst",     32'(bus.slv_wr_req),      32'd0);
        chk("rw_bvalid_rst",  32'(bus.mem_axi_bvalid),  32'd0);
        chk("rw_awready_rst", 32'(bus.mem_axi_awready), 32'd0);
        chk("rw_addr_rst",    bus.slv_wr_addr,          32'd0);
        chk("rw_strb_rst",    32'(bus.slv_wr_strb),     32'd0);
        RSTb = 1'b1;
        tick();
        chk("rw_awready_up", 32'(bus.mem_axi_awready), 32'd1);
        chk("rw_wready_up",  32'(bus.mem_axi_wready),  32'd1);
        chk("rw_bvalid_idle", 32'(bus.mem_axi_bvalid), 32'd0);
        snap();
        bus.mem_axi_awaddr  = 32'h1000_0040;
        bus.mem_axi_wdata   = 32'h0BAD_CAFE;
        bus.mem_axi_wstrb   = 4'b1000;
        bus.mem_axi_awvalid = 1'b1;
        bus.mem_axi_wvalid  = 1'b1;
        tick();
        bus.mem_axi_awvalid = 1'b0;
        bus.mem_axi_wvalid  = 1'b0;
        chk("rw2_req",  32'(bus.slv_wr_req),  32'b0010);
        chk("rw2_addr", bus.slv_wr_addr,      32'h1000_0040);
        chk("rw2_data", bus.slv_wr_data,      32'h0BAD_CAFE);
        chk("rw2_strb", 32'(bus.slv_wr_strb), 32'b1000);
        tick();
        chk("rw2_wait", 32'(bus.mem_axi_bvalid), 32'd0);
        bus.slv_wr_ack = 4'b0010;
        tick();
        bus.slv_wr_ack = '0;
        chk("rw2_bvalid", 32'(bus.mem_axi_bvalid), 32'd1);
        chk("rw2_bresp",  32'(bus.mem_axi_bresp),  32'd0);
        bus.mem_axi_bready = 1'b1;
        tick();
        bus.mem_axi_bready = 1'b0;
        chk("rw2_bvalid_off", 32'(bus.mem_axi_bvalid), 32'd0);
        chk_rises("rw2_rise", -1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
